// File: rtl/serial_adder_if.sv
// Handshake and operand/result bundle for serial_adder.
// master drives the request side; slave (the adder) drives status and result.
interface serial_adder_if #(
  parameter int unsigned WIDTH = 8
);
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] sum;
  logic             carry;

  modport master (
    output start, a, b, cin,
    input  busy, done, sum, carry
  );

  modport slave (
    input  start, a, b, cin,
    output busy, done, sum, carry
  );
endinterface

// File: rtl/serial_adder.sv
// Bit-serial adder: one full-adder cell, registered carry, LSB-first operand shifting.
// Result and carry-out are registered and held until the next addition completes.
module serial_adder #(
  parameter int unsigned WIDTH = 8
) (
  input logic          clk,
  input logic          rst,
  serial_adder_if.slave bus
);
  localparam int unsigned CntW = $clog2(WIDTH);

  typedef enum logic [1:0] {StIdle, StShift, StDone} state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] a_sr_q, a_sr_d;
  logic [WIDTH-1:0] b_sr_q, b_sr_d;
  // Holds only the upper WIDTH-1 partial-sum bits; the final bit joins on completion.
  logic [WIDTH-2:0] s_sr_q, s_sr_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic             c_q, c_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             carry_q, carry_d;

  logic             s_bit;
  logic             c_bit;
  logic [WIDTH-1:0] s_next;
  logic             last_bit;

  assign s_bit    = a_sr_q[0] ^ b_sr_q[0] ^ c_q;
  assign c_bit    = (a_sr_q[0] & b_sr_q[0]) | (a_sr_q[0] & c_q) | (b_sr_q[0] & c_q);
  assign s_next   = {s_bit, s_sr_q};
  assign last_bit = (cnt_q == CntW'(WIDTH - 1));

  always_comb begin
    state_d = state_q;
    a_sr_d  = a_sr_q;
    b_sr_d  = b_sr_q;
    s_sr_d  = s_sr_q;
    cnt_d   = cnt_q;
    c_d     = c_q;
    sum_d   = sum_q;
    carry_d = carry_q;
    case (state_q)
      StIdle: begin
        if (bus.start) begin
          a_sr_d  = bus.a;
          b_sr_d  = bus.b;
          c_d     = bus.cin;
          cnt_d   = '0;
          state_d = StShift;
        end
      end
      StShift: begin
        a_sr_d = {1'b0, a_sr_q[WIDTH-1:1]};
        b_sr_d = {1'b0, b_sr_q[WIDTH-1:1]};
        s_sr_d = s_next[WIDTH-1:1];
        c_d    = c_bit;
        cnt_d  = cnt_q + CntW'(1);
        if (last_bit) begin
          sum_d   = s_next;
          carry_d = c_bit;
          state_d = StDone;
        end
      end
      StDone: begin
        // The edge leaving DONE is also an accept slot, giving a WIDTH+1 issue interval.
        state_d = StIdle;
        if (bus.start) begin
          a_sr_d  = bus.a;
          b_sr_d  = bus.b;
          c_d     = bus.cin;
          cnt_d   = '0;
          state_d = StShift;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      a_sr_q  <= '0;
      b_sr_q  <= '0;
      s_sr_q  <= '0;
      cnt_q   <= '0;
      c_q     <= 1'b0;
      sum_q   <= '0;
      carry_q <= 1'b0;
    end else begin
      state_q <= state_d;
      a_sr_q  <= a_sr_d;
      b_sr_q  <= b_sr_d;
      s_sr_q  <= s_sr_d;
      cnt_q   <= cnt_d;
      c_q     <= c_d;
      sum_q   <= sum_d;
      carry_q <= carry_d;
    end
  end

  assign bus.busy  = (state_q == StShift);
  assign bus.done  = (state_q == StDone);
  assign bus.sum   = sum_q;
  assign bus.carry = carry_q;
endmodule

// File: tb/tb_serial_adder.sv
// Directed bench for serial_adder at WIDTH=8 and WIDTH=2 with hand-computed expectations.
module tb_serial_adder;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  int unsigned n_cmp = 0;
  int unsigned n_err = 0;
  logic [7:0]  hold_sum;
  logic        hold_carry;

  serial_adder_if #(.WIDTH(8)) bus8 ();
  serial_adder_if #(.WIDTH(2)) bus2 ();

  serial_adder #(.WIDTH(8)) u_dut8 (.clk(clk), .rst(rst), .bus(bus8.slave));
  serial_adder #(.WIDTH(2)) u_dut2 (.clk(clk), .rst(rst), .bus(bus2.slave));

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic op8(input logic [7:0] a, input logic [7:0] b, input logic c);
    logic [8:0] exp;
    int lat;
    int busyc;
    exp = {1'b0, a} + {1'b0, b} + {8'd0, c};
    bus8.a = a; bus8.b = b; bus8.cin = c; bus8.start = 1'b1;
    step();
    bus8.start = 1'b0; bus8.a = ~a; bus8.b = ~b; bus8.cin = ~c;
    lat = 0; busyc = 0;
    while (bus8.done !== 1'b1 && lat < 20) begin
      chk("hold_sum", 32'(bus8.sum), 32'(hold_sum));
      chk("hold_carry", 32'(bus8.carry), 32'(hold_carry));
      chk("busy_done_excl", 32'(bus8.busy & bus8.done), 32'd0);
      if (bus8.busy === 1'b1) busyc++;
      step();
      lat++;
    end
    chk("latency8", 32'(lat), 32'd8);
    chk("busy_cycles8", 32'(busyc), 32'd8);
    chk("sum8", 32'(bus8.sum), 32'(exp[7:0]));
    chk("carry8", 32'(bus8.carry), 32'(exp[8]));
    chk("busy_at_done", 32'(bus8.busy), 32'd0);
    hold_sum = exp[7:0];
    hold_carry = exp[8];
    step();
    chk("done_single", 32'(bus8.done), 32'd0);
  endtask

  task automatic op2(input logic [1:0] a, input logic [1:0] b, input logic c);
    logic [2:0] exp;
    int lat;
    exp = {1'b0, a} + {1'b0, b} + {2'd0, c};
    bus2.a = a; bus2.b = b; bus2.cin = c; bus2.start = 1'b1;
    step();
    bus2.start = 1'b0;
    lat = 0;
    while (bus2.done !== 1'b1 && lat < 10) begin
      step();
      lat++;
    end
    chk("latency2", 32'(lat), 32'd2);
    chk("sum2", 32'(bus2.sum), 32'(exp[1:0]));
    chk("carry2", 32'(bus2.carry), 32'(exp[2]));
    step();
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat;
    int gap;
    rst = 1'b1;
    bus8.start = 1'b0; bus8.a = '0; bus8.b = '0; bus8.cin = 1'b0;
    bus2.start = 1'b0; bus2.a = '0; bus2.b = '0; bus2.cin = 1'b0;
    hold_sum = 8'h00; hold_carry = 1'b0;
    step(); step();
    chk("rst_busy", 32'(bus8.busy), 32'd0);
    chk("rst_done", 32'(bus8.done), 32'd0);
    chk("rst_sum", 32'(bus8.sum), 32'd0);
    chk("rst_carry", 32'(bus8.carry), 32'd0);
    rst = 1'b0;

    // Idle with start low
    for (int i = 0; i < 20; i++) begin
      step();
      chk("idle_busy", 32'(bus8.busy), 32'd0);
      chk("idle_done", 32'(bus8.done), 32'd0);
      chk("idle_sum", 32'(bus8.sum), 32'd0);
      chk("idle_carry", 32'(bus8.carry), 32'd0);
    end

    // Carry chain and carry-in path
    op8(8'hFF, 8'h01, 1'b0);
    op8(8'hA5, 8'h5A, 1'b1);
    op8(8'h12, 8'h34, 1'b0);

    // Start held and operands toggled while busy
    bus8.a = 8'h33; bus8.b = 8'h44; bus8.cin = 1'b0; bus8.start = 1'b1;
    step();
    lat = 0;
    while (bus8.done !== 1'b1 && lat < 20) begin
      bus8.a = ~bus8.a; bus8.b = ~bus8.b; bus8.cin = ~bus8.cin;
      step();
      lat++;
    end
    chk("held_latency", 32'(lat), 32'd8);
    chk("held_sum", 32'(bus8.sum), 32'h77);
    chk("held_carry", 32'(bus8.carry), 32'd0);
    bus8.a = 8'h80; bus8.b = 8'h80; bus8.cin = 1'b1;
    step();
    bus8.start = 1'b0;
    gap = 1;
    chk("reaccept_busy", 32'(bus8.busy), 32'd1);
    while (bus8.done !== 1'b1 && gap < 20) begin
      step();
      gap++;
    end
    chk("done_gap", 32'(gap), 32'd9);
    chk("second_sum", 32'(bus8.sum), 32'h01);
    chk("second_carry", 32'(bus8.carry), 32'd1);
    step();
    chk("second_done_single", 32'(bus8.done), 32'd0);

    // Reset during SHIFT
    bus8.a = 8'h55; bus8.b = 8'h22; bus8.cin = 1'b0; bus8.start = 1'b1;
    step();
    bus8.start = 1'b0;
    step(); step(); step();
    #2 rst = 1'b1;
    #1;
    chk("abort_busy", 32'(bus8.busy), 32'd0);
    chk("abort_done", 32'(bus8.done), 32'd0);
    chk("abort_sum", 32'(bus8.sum), 32'd0);
    chk("abort_carry", 32'(bus8.carry), 32'd0);
    step(); step();
    rst = 1'b0;
    for (int i = 0; i < 12; i++) begin
      chk("abort_no_done", 32'(bus8.done), 32'd0);
      step();
    end
    hold_sum = 8'h00; hold_carry = 1'b0;
    op8(8'h0F, 8'h01, 1'b0);

    // Random regression at WIDTH=8
    for (int i = 0; i < 1000; i++) begin
      op8(8'($urandom), 8'($urandom), 1'($urandom));
    end

    // Exhaustive at WIDTH=2
    for (int ia = 0; ia < 4; ia++) begin
      for (int ib = 0; ib < 4; ib++) begin
        for (int ic = 0; ic < 2; ic++) begin
          op2(2'(ia), 2'(ib), 1'(ic));
        end
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
